cache_model_pipelined: RTL

//  Parametrised successor of the single-request cache model: behavioural tag/data/MSI array for core L1 caches.

---
 rtl/cache_model_pipelined.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_model_pipelined.sv
`default_nettype none
// =============================================================================
// cache_model_pipelined : tag/data/MSI row array with fixed-latency in-order
//                         commit, credit-managed response FIFO and exit capture
// Revision 1.0
// =============================================================================
module cache_model_pipelined #(
   parameter int          TAG_W         = 18,
   parameter int          INDEX_W       = 12,
   parameter int          DATA_W        = 32,
   parameter int          MSI_W         = 2,
   parameter int          LATENCY       = 1,
   parameter int          QUEUE_DEPTH   = 2,
   parameter logic [31:0] EXIT_ADDRESS0 = 32'h40001000,
   parameter logic [31:0] EXIT_ADDRESS1 = 32'h80001000,
   localparam int         BE_W          = DATA_W / 8,
   localparam int         REQ_W         = BE_W + TAG_W + INDEX_W + DATA_W + MSI_W + 2,
   localparam int         RESP_W        = TAG_W + DATA_W + MSI_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              put_valid,
   output logic              put_ready,
   input  logic [REQ_W-1:0]  put_request,
   input  logic              get_valid,
   output logic              get_ready,
   output logic [RESP_W-1:0] get_response,
   output logic              finish,
   output logic [DATA_W-1:0] exit_code
);

   localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
   localparam int AW    = TAG_W + INDEX_W + OFF_W;
   localparam int ROWS  = 2 ** INDEX_W;
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

   logic              accept;
   logic              get_fire;
   logic [CNT_W-1:0]  occ;

   logic              cmt_valid;
   logic [REQ_W-1:0]  cmt_req;
   logic [BE_W-1:0]   cmt_be;
   logic [TAG_W-1:0]  cmt_tag;
   logic [INDEX_W-1:0] cmt_idx;
   logic [DATA_W-1:0] cmt_data;
   logic              cmt_msi_valid;
   logic [MSI_W-1:0]  cmt_msi;
   logic              cmt_ignore;

   logic [RESP_W-1:0] mem [ROWS];
   logic [RESP_W-1:0] old_row;
   logic [TAG_W-1:0]  old_tag;
   logic [DATA_W-1:0] old_data;
   logic [MSI_W-1:0]  old_msi;
   logic [TAG_W-1:0]  new_tag;
   logic [DATA_W-1:0] new_data;
   logic [MSI_W-1:0]  new_msi;

   logic [AW-1:0]     addr_full;
   logic [31:0]       addr32;
   logic              is_exit_addr;
   logic              exit_hit;

   logic [RESP_W-1:0] fifo_mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              push;
   logic              pop;

   // A pop in the same cycle frees the credit the new request needs.
   assign get_ready = !rst && (fifo_cnt != '0);
   assign get_fire  = get_valid && get_ready;
   assign put_ready = !rst && ((occ < CNT_W'(QUEUE_DEPTH)) || get_fire);
   assign accept    = put_valid && put_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ <= '0;
      end else begin
         case ({accept && !put_request[0], get_fire})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   generate
      if (LATENCY == 1) begin : g_direct
         assign cmt_valid = accept;
         assign cmt_req   = put_request;
      end else begin : g_pipe
         localparam int STAGES = LATENCY - 1;
         logic [STAGES-1:0] stg_valid;
         logic [REQ_W-1:0]  stg_req [STAGES];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stg_valid <= '0;
            end else begin
               stg_valid[0] <= accept;
               for (int s = 1; s < STAGES; s++) begin
                  stg_valid[s] <= stg_valid[s-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            stg_req[0] <= put_request;
            for (int s = 1; s < STAGES; s++) begin
               stg_req[s] <= stg_req[s-1];
            end
         end

         assign cmt_valid = stg_valid[STAGES-1];
         assign cmt_req   = stg_req[STAGES-1];
      end
   endgenerate

   assign {cmt_be, cmt_tag, cmt_idx, cmt_data, cmt_msi_valid, cmt_msi, cmt_ignore} = cmt_req;

   // Combinational read at the commit point gives in-order visibility without a bypass.
   assign old_row                     = mem[cmt_idx];
   assign {old_tag, old_data, old_msi} = old_row;

   always_comb begin
      new_data = old_data;
      for (int b = 0; b < BE_W; b++) begin
         if (cmt_be[b]) begin
            new_data[8*b +: 8] = cmt_data[8*b +: 8];
         end
      end
   end

   assign new_tag = (cmt_be == '0) ? old_tag : cmt_tag;
   assign new_msi = cmt_msi_valid ? cmt_msi : old_msi;

   assign addr_full    = AW'({cmt_tag, cmt_idx}) << OFF_W;
   assign addr32       = 32'(addr_full);
   assign is_exit_addr = (addr32 == EXIT_ADDRESS0) || (addr32 == EXIT_ADDRESS1);
   assign exit_hit     = cmt_valid && is_exit_addr && (&cmt_be);

   always_ff @(posedge clk) begin
      if (cmt_valid && !is_exit_addr) begin
         mem[cmt_idx] <= {new_tag, new_data, new_msi};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         finish    <= 1'b0;
         exit_code <= '0;
      end else if (exit_hit && !finish) begin
         finish    <= 1'b1;
         exit_code <= cmt_data;
      end
   end

   assign push = cmt_valid && !cmt_ignore;
   assign pop  = get_fire;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= old_row;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && (fifo_cnt == CNT_W'(QUEUE_DEPTH))));
      end
   end

   assign get_response = get_ready ? fifo_mem[rd_ptr] : '0;

endmodule
`default_nettype wire
